// File: rtl/rv64_decode_regfile.sv
// rv64_decode_regfile: RV64I decoder with 32x64 register file (optional write bypass via RF_WRITE_BYPASS_EN)
module rv64_decode_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rf_wdata,
    output logic [10:0]     alu_op,
    output logic [6:0]      sel_nextpc,
    output logic [1:0]      sel_alusrc1,
    output logic [3:0]      sel_alusrc2,
    output logic [XLEN-1:0] rf_rdata1,
    output logic [XLEN-1:0] rf_rdata2,
    output logic [11:0]     immI,
    output logic [20:0]     immJ,
    output logic [19:0]     immU,
    output logic [12:0]     immB,
    output logic [1:0]      sel_rfres,
    output logic [7:0]      mem_wen,
    output logic            mem_ena
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_wen;
    logic            wr_act;
    logic [XLEN-1:0] regs [NREG];

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign wr_act = rst && rd_wen && rd != 5'd0;

    assign immI = (opcode == OPC_STORE) ? {inst[31:25], inst[11:7]} : inst[31:20];
    assign immJ = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign immU = inst[31:12];
    assign immB = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

    // funct3 -> one-hot ALU op for register and immediate arithmetic; alt selects sub/sra
    function automatic logic [10:0] arith_op(input logic [2:0] fn, input logic alt);
        return fn == 3'd0 ? (alt ? 11'h002 : 11'h001) :
               fn == 3'd1 ? 11'h080 :
               fn == 3'd2 ? 11'h004 :
               fn == 3'd3 ? 11'h008 :
               fn == 3'd4 ? 11'h040 :
               fn == 3'd5 ? (alt ? 11'h200 : 11'h100) :
               fn == 3'd6 ? 11'h020 : 11'h010;
    endfunction

    // Control decode; anything unrecognised falls through to pc+4 with everything else off
    always_comb begin
        alu_op      = '0;
        sel_nextpc  = 7'b0000001;
        sel_alusrc1 = '0;
        sel_alusrc2 = '0;
        sel_rfres   = '0;
        mem_wen     = '0;
        mem_ena     = 1'b0;
        rd_wen      = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_op      = 11'h400;
                sel_alusrc1 = 2'b01;
                sel_alusrc2 = 4'b0100;
                sel_rfres   = 2'b01;
                rd_wen      = 1'b1;
            end
            OPC_AUIPC: begin
                alu_op      = 11'h001;
                sel_alusrc1 = 2'b10;
                sel_alusrc2 = 4'b0100;
                sel_rfres   = 2'b01;
                rd_wen      = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                if (opcode == OPC_JAL || f3 == 3'd0) begin
                    alu_op      = 11'h001;
                    sel_nextpc  = (opcode == OPC_JAL) ? 7'b0000010 : 7'b0000100;
                    sel_alusrc1 = 2'b10;
                    sel_alusrc2 = 4'b1000;
                    sel_rfres   = 2'b01;
                    rd_wen      = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (f3[2:1] != 2'b01) begin
                    alu_op      = f3[2] ? (f3[1] ? 11'h008 : 11'h004) : 11'h002;
                    sel_nextpc  = f3[2] ? (f3[0] ? 7'b1000000 : 7'b0100000) : (f3[0] ? 7'b0010000 : 7'b0001000);
                    sel_alusrc1 = 2'b01;
                    sel_alusrc2 = 4'b0001;
                end
            end
            OPC_LOAD: begin
                if (f3 == 3'd3) begin
                    alu_op      = 11'h001;
                    sel_alusrc1 = 2'b01;
                    sel_alusrc2 = 4'b0010;
                    sel_rfres   = 2'b10;
                    mem_ena     = 1'b1;
                    rd_wen      = 1'b1;
                end
            end
            OPC_STORE: begin
                if (!f3[2]) begin
                    alu_op      = 11'h001;
                    sel_alusrc1 = 2'b01;
                    sel_alusrc2 = 4'b0010;
                    mem_ena     = 1'b1;
                    mem_wen     = f3[1:0] == 2'd0 ? 8'h01 : f3[1:0] == 2'd1 ? 8'h03 : f3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
                end
            end
            OPC_OPIMM: begin
                if (f3 == 3'd1 ? inst[31:26] == 6'b000000 :
                    f3 == 3'd5 ? (inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000) : 1'b1) begin
                    alu_op      = arith_op(f3, f3 == 3'd5 && inst[30]);
                    sel_alusrc1 = 2'b01;
                    sel_alusrc2 = 4'b0010;
                    sel_rfres   = 2'b01;
                    rd_wen      = 1'b1;
                end
            end
            OPC_OP: begin
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    alu_op      = arith_op(f3, inst[30]);
                    sel_alusrc1 = 2'b01;
                    sel_alusrc2 = 4'b0001;
                    sel_rfres   = 2'b01;
                    rd_wen      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Register file write; reset clears every entry asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_act) begin
            regs[rd] <= rf_wdata;
        end
    end

    // Combinational read ports; x0 always reads zero
    always_comb begin
`ifdef RF_WRITE_BYPASS_EN
        rf_rdata1 = rs1 == 5'd0 ? '0 : (wr_act && rs1 == rd) ? rf_wdata : regs[rs1];
        rf_rdata2 = rs2 == 5'd0 ? '0 : (wr_act && rs2 == rd) ? rf_wdata : regs[rs2];
`else
        rf_rdata1 = rs1 == 5'd0 ? '0 : regs[rs1];
        rf_rdata2 = rs2 == 5'd0 ? '0 : regs[rs2];
`endif
    end
endmodule

// File: tb/tb_rv64_decode_regfile.sv
// tb_rv64_decode_regfile: directed and randomized checks of decode outputs and register file
module tb_rv64_decode_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [63:0] rf_wdata;
    logic [10:0] alu_op;
    logic [6:0]  sel_nextpc;
    logic [1:0]  sel_alusrc1;
    logic [3:0]  sel_alusrc2;
    logic [63:0] rf_rdata1;
    logic [63:0] rf_rdata2;
    logic [11:0] immI;
    logic [20:0] immJ;
    logic [19:0] immU;
    logic [12:0] immB;
    logic [1:0]  sel_rfres;
    logic [7:0]  mem_wen;
    logic        mem_ena;

    int checks = 0;
    int errors = 0;

`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    rv64_decode_regfile dut (
        .clk(clk), .rst(rst), .inst(inst), .rf_wdata(rf_wdata),
        .alu_op(alu_op), .sel_nextpc(sel_nextpc), .sel_alusrc1(sel_alusrc1),
        .sel_alusrc2(sel_alusrc2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .immI(immI), .immJ(immJ), .immU(immU), .immB(immB),
        .sel_rfres(sel_rfres), .mem_wen(mem_wen), .mem_ena(mem_ena)
    );

    always #5 clk = ~clk;

    typedef enum int {
        K_LUI, K_AUIPC, K_JAL, K_JALR, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
        K_LD, K_SB, K_SH, K_SW, K_SD,
        K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
        K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
        K_EBREAK, K_LW, K_ADDW, K_FENCE, K_NUM
    } kind_t;

    logic [63:0] ref_x [32];
    logic [10:0] e_alu;
    logic [6:0]  e_npc;
    logic [1:0]  e_s1;
    logic [3:0]  e_s2;
    logic [1:0]  e_res;
    logic [7:0]  e_wen;
    logic        e_ena;
    logic        e_wr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Expected control for a mnemonic: ALU op index (-1 none), next-pc index, sources, result, mask, enable, write
    function automatic void expect_ctl(input int a, input int n, input logic [1:0] s1, input logic [3:0] s2,
                                       input logic [1:0] res, input logic [7:0] wen, input logic ena, input logic wr);
        e_alu = (a < 0) ? 11'h000 : 11'(1) << a;
        e_npc = 7'(1) << n;
        e_s1  = s1;
        e_s2  = s2;
        e_res = res;
        e_wen = wen;
        e_ena = ena;
        e_wr  = wr;
    endfunction

    function automatic void model(input kind_t k);
        case (k)
            K_LUI:   expect_ctl(10, 0, 2'b01, 4'b0100, 2'b01, 8'h00, 1'b0, 1'b1);
            K_AUIPC: expect_ctl(0, 0, 2'b10, 4'b0100, 2'b01, 8'h00, 1'b0, 1'b1);
            K_JAL:   expect_ctl(0, 1, 2'b10, 4'b1000, 2'b01, 8'h00, 1'b0, 1'b1);
            K_JALR:  expect_ctl(0, 2, 2'b10, 4'b1000, 2'b01, 8'h00, 1'b0, 1'b1);
            K_BEQ:   expect_ctl(1, 3, 2'b01, 4'b0001, 2'b00, 8'h00, 1'b0, 1'b0);
            K_BNE:   expect_ctl(1, 4, 2'b01, 4'b0001, 2'b00, 8'h00, 1'b0, 1'b0);
            K_BLT:   expect_ctl(2, 5, 2'b01, 4'b0001, 2'b00, 8'h00, 1'b0, 1'b0);
            K_BGE:   expect_ctl(2, 6, 2'b01, 4'b0001, 2'b00, 8'h00, 1'b0, 1'b0);
            K_BLTU:  expect_ctl(3, 5, 2'b01, 4'b0001, 2'b00, 8'h00, 1'b0, 1'b0);
            K_BGEU:  expect_ctl(3, 6, 2'b01, 4'b0001, 2'b00, 8'h00, 1'b0, 1'b0);
            K_LD:    expect_ctl(0, 0, 2'b01, 4'b0010, 2'b10, 8'h00, 1'b1, 1'b1);
            K_SB:    expect_ctl(0, 0, 2'b01, 4'b0010, 2'b00, 8'h01, 1'b1, 1'b0);
            K_SH:    expect_ctl(0, 0, 2'b01, 4'b0010, 2'b00, 8'h03, 1'b1, 1'b0);
            K_SW:    expect_ctl(0, 0, 2'b01, 4'b0010, 2'b00, 8'h0F, 1'b1, 1'b0);
            K_SD:    expect_ctl(0, 0, 2'b01, 4'b0010, 2'b00, 8'hFF, 1'b1, 1'b0);
            K_ADDI:  expect_ctl(0, 0, 2'b01, 4'b0010, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SLTI:  expect_ctl(2, 0, 2'b01, 4'b0010, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SLTIU: expect_ctl(3, 0, 2'b01, 4'b0010, 2'b01, 8'h00, 1'b0, 1'b1);
            K_XORI:  expect_ctl(6, 0, 2'b01, 4'b0010, 2'b01, 8'h00, 1'b0, 1'b1);
            K_ORI:   expect_ctl(5, 0, 2'b01, 4'b0010, 2'b01, 8'h00, 1'b0, 1'b1);
            K_ANDI:  expect_ctl(4, 0, 2'b01, 4'b0010, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SLLI:  expect_ctl(7, 0, 2'b01, 4'b0010, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SRLI:  expect_ctl(8, 0, 2'b01, 4'b0010, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SRAI:  expect_ctl(9, 0, 2'b01, 4'b0010, 2'b01, 8'h00, 1'b0, 1'b1);
            K_ADD:   expect_ctl(0, 0, 2'b01, 4'b0001, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SUB:   expect_ctl(1, 0, 2'b01, 4'b0001, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SLL:   expect_ctl(7, 0, 2'b01, 4'b0001, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SLT:   expect_ctl(2, 0, 2'b01, 4'b0001, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SLTU:  expect_ctl(3, 0, 2'b01, 4'b0001, 2'b01, 8'h00, 1'b0, 1'b1);
            K_XOR:   expect_ctl(6, 0, 2'b01, 4'b0001, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SRL:   expect_ctl(8, 0, 2'b01, 4'b0001, 2'b01, 8'h00, 1'b0, 1'b1);
            K_SRA:   expect_ctl(9, 0, 2'b01, 4'b0001, 2'b01, 8'h00, 1'b0, 1'b1);
            K_OR:    expect_ctl(5, 0, 2'b01, 4'b0001, 2'b01, 8'h00, 1'b0, 1'b1);
            K_AND:   expect_ctl(4, 0, 2'b01, 4'b0001, 2'b01, 8'h00, 1'b0, 1'b1);
            default: expect_ctl(-1, 0, 2'b00, 4'b0000, 2'b00, 8'h00, 1'b0, 1'b0);
        endcase
    endfunction

    function automatic logic [31:0] gen(input kind_t k, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [11:0] i12, input logic [12:0] i13, input logic [19:0] i20,
                                        input logic [20:0] i21, input logic [5:0] sh);
        case (k)
            K_LUI:    return {i20, rd, 7'b0110111};
            K_AUIPC:  return {i20, rd, 7'b0010111};
            K_JAL:    return enc_j(i21, rd);
            K_JALR:   return enc_i(i12, rs1, 3'd0, rd, 7'b1100111);
            K_BEQ:    return enc_b(i13, rs2, rs1, 3'd0);
            K_BNE:    return enc_b(i13, rs2, rs1, 3'd1);
            K_BLT:    return enc_b(i13, rs2, rs1, 3'd4);
            K_BGE:    return enc_b(i13, rs2, rs1, 3'd5);
            K_BLTU:   return enc_b(i13, rs2, rs1, 3'd6);
            K_BGEU:   return enc_b(i13, rs2, rs1, 3'd7);
            K_LD:     return enc_i(i12, rs1, 3'd3, rd, 7'b0000011);
            K_SB:     return enc_s(i12, rs2, rs1, 3'd0);
            K_SH:     return enc_s(i12, rs2, rs1, 3'd1);
            K_SW:     return enc_s(i12, rs2, rs1, 3'd2);
            K_SD:     return enc_s(i12, rs2, rs1, 3'd3);
            K_ADDI:   return enc_i(i12, rs1, 3'd0, rd, OP_I);
            K_SLTI:   return enc_i(i12, rs1, 3'd2, rd, OP_I);
            K_SLTIU:  return enc_i(i12, rs1, 3'd3, rd, OP_I);
            K_XORI:   return enc_i(i12, rs1, 3'd4, rd, OP_I);
            K_ORI:    return enc_i(i12, rs1, 3'd6, rd, OP_I);
            K_ANDI:   return enc_i(i12, rs1, 3'd7, rd, OP_I);
            K_SLLI:   return enc_i({6'b000000, sh}, rs1, 3'd1, rd, OP_I);
            K_SRLI:   return enc_i({6'b000000, sh}, rs1, 3'd5, rd, OP_I);
            K_SRAI:   return enc_i({6'b010000, sh}, rs1, 3'd5, rd, OP_I);
            K_ADD:    return enc_r(7'h00, rs2, rs1, 3'd0, rd, OP_R);
            K_SUB:    return enc_r(7'h20, rs2, rs1, 3'd0, rd, OP_R);
            K_SLL:    return enc_r(7'h00, rs2, rs1, 3'd1, rd, OP_R);
            K_SLT:    return enc_r(7'h00, rs2, rs1, 3'd2, rd, OP_R);
            K_SLTU:   return enc_r(7'h00, rs2, rs1, 3'd3, rd, OP_R);
            K_XOR:    return enc_r(7'h00, rs2, rs1, 3'd4, rd, OP_R);
            K_SRL:    return enc_r(7'h00, rs2, rs1, 3'd5, rd, OP_R);
            K_SRA:    return enc_r(7'h20, rs2, rs1, 3'd5, rd, OP_R);
            K_OR:     return enc_r(7'h00, rs2, rs1, 3'd6, rd, OP_R);
            K_AND:    return enc_r(7'h00, rs2, rs1, 3'd7, rd, OP_R);
            K_EBREAK: return 32'h00100073;
            K_LW:     return enc_i(i12, rs1, 3'd2, rd, 7'b0000011);
            K_ADDW:   return enc_r(7'h00, rs2, rs1, 3'd0, rd, 7'b0111011);
            default:  return enc_i(i12, rs1, i13[2:0], rd, 7'b0001111);
        endcase
    endfunction

    function automatic logic [63:0] ref_read(input logic [4:0] r, input logic [4:0] wr_rd, input logic [63:0] wd);
        return (r == 5'd0) ? 64'd0 : (BYP && e_wr && wr_rd != 5'd0 && r == wr_rd) ? wd : ref_x[r];
    endfunction

    initial begin
        kind_t       k;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] i12;
        logic [12:0] i13;
        logic [19:0] i20;
        logic [20:0] i21;
        logic [5:0]  sh;
        for (int i = 0; i < 32; i++) ref_x[i] = 64'd0;
        rst = 1'b0;
        inst = 32'h00000013;
        rf_wdata = 64'd0;
        repeat (2) @(negedge clk);
        inst = enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd0, OP_R);
        #1;
        chk("reset_rd1", rf_rdata1, 64'd0);
        chk("reset_rd2", rf_rdata2, 64'd0);
        rst = 1'b1;
        inst = enc_i(12'd0, 5'd0, 3'd0, 5'd5, OP_I);
        rf_wdata = 64'h1234;
        @(negedge clk);
        inst = enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd0, OP_R);
        #1;
        chk("x5_written", rf_rdata1, 64'h1234);
        #2;
        rst = 1'b0;
        #1;
        chk("async_clear", rf_rdata1, 64'd0);
        inst = enc_i(12'd0, 5'd0, 3'd0, 5'd5, OP_I);
        @(negedge clk);
        inst = enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd0, OP_R);
        #1;
        chk("no_write_in_reset", rf_rdata2, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        inst = 32'h00500093;
        rf_wdata = 64'd5;
        #1;
        chk("addi_alu", alu_op, 11'h001);
        chk("addi_src1", sel_alusrc1, 2'b01);
        chk("addi_src2", sel_alusrc2, 4'b0010);
        chk("addi_immI", immI, 12'h005);
        chk("addi_rfres", sel_rfres, 2'b01);
        @(negedge clk);
        inst = enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd0, OP_R);
        #1;
        chk("addi_x1", rf_rdata1, 64'd5);
        ref_x[1] = 64'd5;

        inst = 32'h00113423;
        rf_wdata = 64'hDEAD;
        #1;
        chk("sd_ena", mem_ena, 1'b1);
        chk("sd_wen", mem_wen, 8'hFF);
        chk("sd_immI", immI, 12'h008);
        chk("sd_rfres", sel_rfres, 2'b00);
        chk("sd_rd2", rf_rdata2, 64'd5);
        @(negedge clk);
        inst = enc_r(7'h00, 5'd0, 5'd8, 3'd0, 5'd0, OP_R);
        #1;
        chk("sd_nowrite", rf_rdata1, 64'd0);

        inst = 32'h010000EF;
        rf_wdata = 64'h44;
        #1;
        chk("jal_npc", sel_nextpc, 7'b0000010);
        chk("jal_immJ", immJ, 21'h00010);
        chk("jal_src1", sel_alusrc1, 2'b10);
        chk("jal_src2", sel_alusrc2, 4'b1000);
        @(negedge clk);
        inst = enc_r(7'h00, 5'd1, 5'd0, 3'd0, 5'd0, OP_R);
        #1;
        chk("jal_x1", rf_rdata2, 64'h44);
        ref_x[1] = 64'h44;

        inst = 32'h00208463;
        rf_wdata = 64'h77;
        #1;
        chk("beq_npc", sel_nextpc, 7'b0001000);
        chk("beq_alu", alu_op, 11'h002);
        chk("beq_immB", immB, 13'h008);
        @(negedge clk);
        inst = enc_r(7'h00, 5'd0, 5'd8, 3'd0, 5'd0, OP_R);
        #1;
        chk("beq_nowrite", rf_rdata1, 64'd0);

        inst = 32'h00100013;
        rf_wdata = 64'd1;
        @(negedge clk);
        inst = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd0, OP_R);
        #1;
        chk("x0_zero", rf_rdata1, 64'd0);

        inst = 32'hFFFFFFFF;
        rf_wdata = 64'h99;
        #1;
        chk("ill_npc", sel_nextpc, 7'b0000001);
        chk("ill_ena", mem_ena, 1'b0);
        chk("ill_wen", mem_wen, 8'h00);
        chk("ill_alu", alu_op, 11'h000);
        @(negedge clk);
        inst = enc_r(7'h00, 5'd31, 5'd0, 3'd0, 5'd0, OP_R);
        #1;
        chk("ill_nowrite", rf_rdata2, 64'd0);

        for (int n = 0; n < 400; n++) begin
            k   = kind_t'($urandom_range(0, K_NUM - 1));
            rd  = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            i12 = 12'($urandom);
            i13 = {12'($urandom), 1'b0};
            i20 = 20'($urandom);
            i21 = {20'($urandom), 1'b0};
            sh  = 6'($urandom);
            inst = gen(k, rd, rs1, rs2, i12, i13, i20, i21, sh);
            rf_wdata = {$urandom, $urandom};
            model(k);
            #1;
            chk($sformatf("%s_alu", k.name()), alu_op, e_alu);
            chk($sformatf("%s_npc", k.name()), sel_nextpc, e_npc);
            if (k != K_LUI) chk($sformatf("%s_src1", k.name()), sel_alusrc1, e_s1);
            chk($sformatf("%s_src2", k.name()), sel_alusrc2, e_s2);
            chk($sformatf("%s_rfres", k.name()), sel_rfres, e_res);
            chk($sformatf("%s_wen", k.name()), mem_wen, e_wen);
            chk($sformatf("%s_ena", k.name()), mem_ena, e_ena);
            chk($sformatf("%s_rd1", k.name()), rf_rdata1, ref_read(inst[19:15], inst[11:7], rf_wdata));
            chk($sformatf("%s_rd2", k.name()), rf_rdata2, ref_read(inst[24:20], inst[11:7], rf_wdata));
            if (k inside {K_JALR, K_LD, K_SB, K_SH, K_SW, K_SD, K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI})
                chk($sformatf("%s_immI", k.name()), immI, i12);
            if (k inside {K_SLLI, K_SRLI}) chk($sformatf("%s_sh", k.name()), immI, {6'b000000, sh});
            if (k == K_SRAI) chk("K_SRAI_sh", immI, {6'b010000, sh});
            if (k inside {K_LUI, K_AUIPC}) chk($sformatf("%s_immU", k.name()), immU, i20);
            if (k == K_JAL) chk("K_JAL_immJ", immJ, i21);
            if (k inside {K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU}) chk($sformatf("%s_immB", k.name()), immB, i13);
            if (e_wr && rd != 5'd0) ref_x[rd] = rf_wdata;
            @(negedge clk);
        end

        for (int r = 0; r < 32; r++) begin
            inst = enc_r(7'h00, 5'(r), 5'(r), 3'd0, 5'd0, OP_R);
            #1;
            chk($sformatf("final_x%0d", r), rf_rdata1, ref_x[r]);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
